// File: rtl/clk_div_bank_if.sv
// Configuration bus for clk_div_bank.
// The master drives one write per cycle with a single-cycle cfg_we strobe;
// there is no ready signal because every cycle can accept a write.
// The slave returns cfg_err, a registered one-cycle pulse that follows a
// rejected write.
interface clk_div_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             cfg_we;
  logic [CW-1:0]    cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_mode;
  logic             cfg_sync;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_ch, cfg_div, cfg_mode, cfg_sync,
    input  cfg_err
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, cfg_mode, cfg_sync,
    output cfg_err
  );
endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider and tick generator.
// Each channel counts enabled cycles up to its divisor and then emits a
// one-cycle tick. div_out is either a 50% square wave (toggle mode) or a
// copy of the tick (pulse mode). Divisor writes either take effect at once
// (sync) or wait in a shadow register until the channel's next terminal
// count, so a running output never sees a truncated period.
module clk_div_bank #(
  parameter int               CHANNELS    = 4,
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(10000000)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  clk_div_bank_if.slave       cfg,
  output logic [CHANNELS-1:0] div_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] cfg_pending
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [WIDTH-1:0]    cnt        [CHANNELS];
  logic [WIDTH-1:0]    active_div [CHANNELS];
  logic [WIDTH-1:0]    shadow_div [CHANNELS];
  logic [CHANNELS-1:0] active_mode;
  logic [CHANNELS-1:0] shadow_mode;

  logic                wr_ok;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] tc;

  // Decode the write and find which channels reach terminal count this cycle.
  always_comb begin
    wr_ok = 1'b0;
    hit   = '0;
    tc    = '0;
    wr_ok = cfg.cfg_we && (cfg.cfg_div != '0) && (32'(cfg.cfg_ch) < CHANNELS);
    for (int c = 0; c < CHANNELS; c++) begin
      hit[c] = wr_ok && (cfg.cfg_ch == CW'(c));
      tc[c]  = en && (cnt[c] == active_div[c] - WIDTH'(1));
    end
  end

  // Per-channel counters, outputs and the shadowed configuration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg.cfg_err <= 1'b0;
      div_out     <= '0;
      tick        <= '0;
      cfg_pending <= '0;
      active_mode <= '0;
      shadow_mode <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c]        <= '0;
        active_div[c] <= DEFAULT_DIV;
        shadow_div[c] <= DEFAULT_DIV;
      end
    end else begin
      cfg.cfg_err <= cfg.cfg_we && !wr_ok;
      for (int c = 0; c < CHANNELS; c++) begin
        if (hit[c] && cfg.cfg_sync) begin
          // Immediate write wins over anything else happening on this edge.
          active_div[c]  <= cfg.cfg_div;
          shadow_div[c]  <= cfg.cfg_div;
          active_mode[c] <= cfg.cfg_mode;
          shadow_mode[c] <= cfg.cfg_mode;
          cnt[c]         <= '0;
          div_out[c]     <= 1'b0;
          tick[c]        <= 1'b0;
          cfg_pending[c] <= 1'b0;
        end else begin
          if (tc[c]) begin
            cnt[c]  <= '0;
            tick[c] <= 1'b1;
            if (cfg_pending[c]) begin
              // Shadow is applied using its value before this edge's write.
              active_div[c]  <= shadow_div[c];
              active_mode[c] <= shadow_mode[c];
              cfg_pending[c] <= 1'b0;
              div_out[c]     <= shadow_mode[c] ? 1'b1 : ~div_out[c];
            end else begin
              div_out[c]     <= active_mode[c] ? 1'b1 : ~div_out[c];
            end
          end else begin
            if (en) begin
              cnt[c] <= cnt[c] + WIDTH'(1);
            end
            tick[c] <= 1'b0;
            if (active_mode[c]) begin
              div_out[c] <= 1'b0;
            end
          end
          // A deferred write lands after any application on this edge,
          // so it stays pending until the following terminal count.
          if (hit[c]) begin
            shadow_div[c]  <= cfg.cfg_div;
            shadow_mode[c] <= cfg.cfg_mode;
            cfg_pending[c] <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel programmable clock divider and tick generator that supersedes the fixed single-output divider. Each of `CHANNELS` independent channels divides `clk` by a runtime-programmable divisor and produces both a divided square wave and a one-cycle tick strobe. Divisor changes are shadowed and applied glitch-free at the channel's next terminal count, or immediately on request. It feeds the display-scan, debounce and counter-enable logic that each previously needed a dedicated divider.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `WIDTH`, 32: counter and divisor width.
- `DEFAULT_DIV`, 10000000: per-channel divisor loaded at reset (1 ≤ value < 2^WIDTH).
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: global count enable; 0 freezes all channels.
- `cfg_we` in 1: configuration write strobe, one cycle.
- `cfg_ch` in max(1,$clog2(CHANNELS)): target channel of the write.
- `cfg_div` in WIDTH: new divisor.
- `cfg_mode` in 1: 0 = toggle mode, 1 = pulse mode.
- `cfg_sync` in 1: 1 = apply the write immediately; 0 = apply at the next terminal count.
- `cfg_err` out 1: one-cycle pulse on a rejected write.
- `div_out` out CHANNELS: divided output per channel.
- `tick` out CHANNELS: one-cycle strobe at each terminal count.
- `cfg_pending` out CHANNELS: shadow write awaiting application.

## Operation
- Per-channel state: `cnt[WIDTH]`, active `div` and `mode`, shadow `sdiv` and `smode`, and `pend`.
- Reset (`rst`=0, async) sets, for every channel: `cnt`=0, `div`=`sdiv`=DEFAULT_DIV, `mode`=`smode`=0, `pend`=0. Outputs `div_out`=0, `tick`=0, `cfg_pending`=0 and `cfg_err`=0. This applies mid-count as well; any pending write is discarded.
- Terminal count (TC) means `en`=1 and `cnt`==`div`-1. This is an unsigned compare; `div`=1 gives a TC every enabled cycle.
- On a TC edge:
  - `cnt` ← 0 and `tick` ← 1.
  - Toggle mode: `div_out` ← ~`div_out`, giving period 2·`div` and 50% duty.
  - Pulse mode: `div_out` ← 1, so `div_out` equals `tick`.
- On a non-TC edge with `en`=1: `cnt` ← `cnt`+1 and `tick` ← 0. In pulse mode `div_out` ← 0.
- With `en`=0: `cnt` and toggle-mode `div_out` hold. `tick` ← 0, and pulse-mode `div_out` ← 0.
- Write rejection:
  - A write is rejected when `cfg_div`==0 or `cfg_ch` ≥ CHANNELS.
  - On rejection `cfg_err` pulses one cycle and no state changes.
- Accepted write with `cfg_sync`=0:
  - `sdiv`/`smode` ← `cfg_div`/`cfg_mode`, and `pend` ← 1.
  - A later write before application overwrites the shadow (last write wins).
- Application of a pending write:
  - It occurs at the first TC strictly after the write edge.
  - On that edge: `div`/`mode` ← shadow, `pend` ← 0, `cnt` ← 0, and `tick` pulses normally.
  - `div_out` ← 1 if the new mode is pulse. Otherwise `div_out` toggles.
- Write coinciding with a TC on the same channel: that TC completes with the old shadow state. The new values are stored and stay pending until the following TC.
- Accepted write with `cfg_sync`=1:
  - On the write edge: `div`/`mode`/`sdiv`/`smode` ← new values, `cnt` ← 0, `div_out` ← 0, `tick` ← 0, `pend` ← 0.
  - This works regardless of `en` and overrides a coincident TC.
- Channels are fully independent; a write affects only `cfg_ch`.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- `tick` is high exactly one cycle per TC.
- With `en` held high from the first edge after reset release:
  - The first `tick` is high after the `div`-th edge.
  - Subsequent ticks are every `div` cycles.
- Pulse-mode `div_out` has period `div` and is high for one cycle.
- Toggle-mode `div_out` has period 2·`div` cycles.
- `cfg_err` is registered: high the cycle after the bad write edge, for one cycle.
- `cfg_pending[ch]` rises the cycle after the write edge and falls the cycle after the applying TC edge.
- Throughput is one write per cycle; back-to-back writes to different channels are all accepted.

## Test plan
- Reset with default `div`=5 (DEFAULT_DIV overridden to 5), `en`=1, toggle mode -> `tick` high every 5 cycles; `div_out` toggles with period 10; all outputs 0 during `rst`=0.
- Ch1 write `div`=3, `mode`=1, `sync`=0, issued mid-count at `cnt`=2 of `div`=5 -> `cfg_pending[1]`=1 until old TC. Then ticks every 3 cycles and `div_out[1]`==`tick[1]`. Other channels are unchanged.
- Write coinciding with a TC (ch0, `div`=7) -> current TC uses the old divisor, the next interval is 5 cycles under the old divisor, then ticks every 7.
- `sync`=1 write `div`=1 to ch2 with `en`=0 -> immediate `cnt`=0 and `div_out`=0. When `en`=1, `tick[2]` is high every cycle and toggle `div_out[2]` = clk/2.
- `cfg_div`=0 and `cfg_ch`=CHANNELS writes -> `cfg_err` one-cycle pulse each; no `cfg_pending` change and periods unchanged.
- `rst` asserted while `cfg_pending[0]`=1 and mid-count -> all outputs 0 immediately (asynchronous). After release, ch0 runs at DEFAULT_DIV and the pending write is lost.
